// File: rtl/pipeline_sub_if.sv
// Operand/result handshake bundle for pipeline_sub: valid/ready on the operand side and on the result side.
// The master modport is the traffic source/sink; the slave modport is the subtractor itself.
interface pipeline_sub_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ina;
  logic [7:0] inb;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;

  modport master (
    output in_valid, ina, inb, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, ina, inb, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/pipeline_sub.sv
// Four-stage 8-bit subtractor (2 bits per stage), result 4 cycles after acceptance.
// Backpressure: an unconsumed result freezes the whole pipeline and drops in_ready.
module pipeline_sub (
  input  logic          clk,
  input  logic          rst,
  pipeline_sub_if.slave io,
  output logic          busy
);

  typedef struct packed {
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
  } s0_t;

  typedef struct packed {
    logic       vld;
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] d;
    logic       br;
  } s1_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       br;
  } s2_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] a;
    logic [1:0] b;
    logic [5:0] d;
    logic       br;
  } s3_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] d;
    logic       br;
  } s4_t;

  s0_t s0;
  s1_t s1;
  s2_t s2;
  s3_t s3;
  s4_t s4;

  logic       stall;
  logic [2:0] r1;
  logic [2:0] r2;
  logic [2:0] r3;
  logic [2:0] r4;

  // 2-bit slice subtract; bit 2 of the 3-bit wrap is set exactly when the slice underflows.
  function automatic logic [2:0] sub2(input logic [1:0] x, input logic [1:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {2'b00, bi};
  endfunction

  assign stall       = s4.vld && !io.out_ready;
  assign io.in_ready = !stall;

  assign r1 = sub2(s0.a[1:0], s0.b[1:0], s0.bi);
  assign r2 = sub2(s1.a[1:0], s1.b[1:0], s1.br);
  assign r3 = sub2(s2.a[1:0], s2.b[1:0], s2.br);
  assign r4 = sub2(s3.a,      s3.b,      s3.br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else if (!stall) begin
      s0.vld <= io.in_valid;
      if (io.in_valid) begin
        s0.a  <= io.ina;
        s0.b  <= io.inb;
        s0.bi <= io.bin;
      end

      s1 <= '{vld: s0.vld, a: s0.a[7:2], b: s0.b[7:2], d: r1[1:0], br: r1[2]};
      s2 <= '{vld: s1.vld, a: s1.a[5:2], b: s1.b[5:2], d: {r2[1:0], s1.d}, br: r2[2]};
      s3 <= '{vld: s2.vld, a: s2.a[3:2], b: s2.b[3:2], d: {r3[1:0], s2.d}, br: r3[2]};
      s4 <= '{vld: s3.vld, d: {r4[1:0], s3.d}, br: r4[2]};
    end
  end

  assign io.out_valid = s4.vld;
  assign io.diff      = s4.d;
  assign io.bout      = s4.br;
  assign busy         = s0.vld | s1.vld | s2.vld | s3.vld | s4.vld;

endmodule

// File: tb/tb_pipeline_sub.sv
// Scoreboard bench for pipeline_sub: the driver pushes arithmetic expectations with their due cycle,
// an independent monitor pops and compares whenever a result is consumed.
module tb_pipeline_sub;

  logic clk;
  logic rst;
  logic busy;

  pipeline_sub_if io();

  pipeline_sub dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .busy (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   adv   = 0;
  bit   rdone;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts edges on which the pipeline is allowed to move; a frozen edge does not count.
  always @(posedge clk) begin
    if (!(io.out_valid && !io.out_ready)) adv++;
  end

  logic       pv_stall = 0;
  logic [7:0] pv_d;
  logic       pv_b;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv_stall = 0;
    end else begin
      chk("in_ready", io.in_ready, !(io.out_valid && !io.out_ready));
      if (pv_stall) begin
        chk("hold_valid", io.out_valid, 1);
        chk("hold_diff", io.diff, pv_d);
        chk("hold_bout", io.bout, pv_b);
      end
      if (io.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", io.out_valid, 0);
        end else if (io.out_ready) begin
          e = q.pop_front();
          chk("diff", io.diff, e.d);
          chk("bout", io.bout, e.bo);
          chk("latency", adv, e.due);
        end
      end else if (q.size() > 0 && adv >= q[0].due) begin
        chk("late_valid", io.out_valid, 1);
      end
      pv_stall = io.out_valid && !io.out_ready;
      pv_d     = io.diff;
      pv_b     = io.bout;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int d;
    bit ok;
    ok = 0;
    io.in_valid = 1;
    io.ina = a;
    io.inb = b;
    io.bin = bi;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        d = int'(a) - int'(b) - int'(bi);
        q.push_back('{d: d[7:0], bo: (d < 0), due: adv + 5});
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    io.in_valid = 0;
    if (!ok) chk("accept_timeout", ok, 1);
  endtask

  task automatic idle(input int n);
    io.in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    chk("drain_left", q.size(), 0);
    repeat (2) @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_out_valid", io.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    io.in_valid  = 0;
    io.ina       = 0;
    io.inb       = 0;
    io.bin       = 0;
    io.out_ready = 1;
    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", io.diff, 8'h00);
    chk("rst_bout", io.bout, 0);
    @(posedge clk);
    #1 rst = 0;
    #1 chk("rst_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;

    // single op and borrow-ripple corners
    send(8'h35, 8'h12, 1'b0);
    drain();
    send(8'h80, 8'h7F, 1'b1);
    drain();
    send(8'h00, 8'h01, 1'b0);
    drain();
    send(8'h00, 8'h00, 1'b1);
    drain();
    send(8'h42, 8'h42, 1'b1);
    send(8'hFF, 8'h00, 1'b0);
    drain();

    // 16 back-to-back sets; any gap would show up as a latency miscompare
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    drain();

    // backpressure: out_ready low for 3 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1 io.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 io.out_ready = 1;
      end
    join
    drain();

    // bubbles 1,0,1,0,1
    send(8'h10, 8'h01, 1'b0);
    idle(1);
    send(8'h20, 8'h30, 1'b0);
    idle(1);
    send(8'h05, 8'h05, 1'b0);
    drain();

    // reset with three sets in flight
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b1);
    send(8'h55, 8'h66, 1'b0);
    #2 rst = 1;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_diff", io.diff, 8'h00);
    q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    idle(1);
    chk("post_rst_in_ready", io.in_ready, 1);
    send(8'hA7, 8'h3C, 1'b1);
    drain();

    // random traffic with random gaps and random backpressure
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(8'($urandom), 8'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 io.out_ready = ($urandom_range(0, 3) != 0);
        end
        io.out_ready = 1;
      end
    join
    io.out_ready = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_sub.md
# pipeline_sub

Four-stage pipelined 8-bit unsigned subtractor with borrow-in/borrow-out, the complement of the team's four-stage pipelined adder. It resolves the difference two bits per stage, passing borrow between stages. A valid/ready handshake on both ends lets it sit in a streaming datapath. It is used wherever the datapath needs `a - b` at full clock rate with short per-stage carry chains.

## Interface
- No parameters; data width is fixed at 8 bits.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operand set is present on ina/inb/bin.
- in_ready  output  1  the block accepts an operand set this cycle.
- ina  input  8  minuend.
- inb  input  8  subtrahend.
- bin  input  1  borrow-in, subtracted at bit 0.
- out_valid  output  1  diff/bout hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- diff  output  8  (ina - inb - bin) mod 256.
- bout  output  1  borrow-out; 1 iff ina < inb + bin, unsigned.
- busy  output  1  at least one stage holds a valid operand set.

## Operation
- An operand set is accepted on a rising edge where in_valid && in_ready.
- Stage S0 is the input register. It holds ina, inb, bin and a valid bit.
- Stage S1 computes slice [1:0]: {b1, d[1:0]} = a[1:0] - b[1:0] - bin.
- S1 also forwards the unused operand bits a[7:2] and b[7:2].
- Stage S2 computes slice [3:2] using b1 and produces borrow b2.
- S2 carries d[1:0] forward and forwards a[7:4] and b[7:4].
- Stage S3 computes slice [5:4] using b2 and produces borrow b3.
- Stage S4 computes slice [7:6] using b3. Its borrow is bout.
- S4 is the output register driving diff, bout and out_valid.
- Each slice borrow is 1 iff the 2-bit minuend < subtrahend slice + incoming borrow.
- Every stage carries its own valid bit. Bubbles travel with the data.
- Stall condition: stall = out_valid && !out_ready.
- On a stall, every stage register (data and valid) holds its value.
- in_ready = !stall. It is combinational and does not depend on in_valid.
- With no stall, all stages advance every edge.
- With no stall, S0 loads the input when in_valid is high and loads a bubble otherwise.
- Bubbles are not compressed during a stall. The pipeline freezes as a whole.
- busy = OR of the valid bits of S0..S4.
- Results leave in acceptance order. No set is dropped or duplicated.

## Timing
- Reset, asynchronous on rst high:
  - all stage valid bits = 0;
  - all stage data registers = 0;
  - diff = 0x00, bout = 0, out_valid = 0, busy = 0;
  - in_ready = 1 once rst is low, because out_valid = 0.
- Latency: a set accepted at edge N appears on diff/bout with out_valid = 1 after edge N+4, assuming no stall in between.
- Throughput: one set per clock with out_ready held high.
- diff, bout and out_valid stay stable across every stalled cycle.
- The output is consumed on an edge where out_valid && out_ready. On that same edge, S4 loads the S3 contents, which may be a bubble.
- in_valid && out_valid && out_ready on the same edge: the new set enters S0 and S4 advances. Both happen with no conflict.
- in_valid high while stalled: the set is not accepted. The source must hold it until in_ready = 1.
- Reset asserted mid-stream: all in-flight sets are discarded immediately, with no partial results. After rst deasserts, the first accepted set behaves as from cold.
- Edge cases:
  - bin = 1 with ina = inb gives diff = 0xFF, bout = 1.
  - ina = 0xFF, inb = 0x00, bin = 0 gives diff = 0xFF, bout = 0.

## Test plan
- Single op: ina=0x35, inb=0x12, bin=0 accepted at edge N.
  - Required: out_valid=1 after edge N+4 with diff=0x23, bout=0.
  - Required: out_valid=0 at every other time.
- Borrow ripple:
  - 0x80-0x7F-1 -> diff 0x00, bout 0.
  - 0x00-0x01-0 -> diff 0xFF, bout 1.
  - 0x00-0x00-1 -> diff 0xFF, bout 1.
  - Each with 4-cycle latency.
- Streaming: 16 back-to-back random sets with out_ready=1.
  - Required: in_ready stays 1 and outputs appear on 16 consecutive cycles.
  - Required: each output matches a reference model, in order.
- Backpressure: stream 8 sets and drop out_ready for 3 cycles mid-stream.
  - Required: in_ready=0 and diff/bout/out_valid frozen while out_ready is low.
  - Required: all 8 results delivered in order, none lost or duplicated.
- Bubbles: toggle in_valid 1,0,1,0,1.
  - Required: out_valid shows pattern 1,0,1,0,1 delayed by 4 cycles.
  - Required: busy=0 once the last result is consumed.
- Reset mid-stream: assert rst with 3 sets in flight.
  - Required: out_valid=0, busy=0, diff=0x00 immediately.
  - Required: a set accepted after release yields the correct result 4 cycles later.
